// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch path.
// Holds the sequencer state encoding and the address-legality helpers.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } imem_state_e;

  localparam int          ROM_ADDR_W_DEF  = 19;
  localparam int          IMEM_BYTES      = 1 << 20;
  localparam logic [31:0] IMEM_ALIGN_MASK = 32'h0000_0003;

  // Misaligned or beyond the 1 MiB instruction window.
  function automatic logic imem_addr_fault(input logic [31:0] addr);
    return ((addr & IMEM_ALIGN_MASK) != 32'h0) || (addr >= 32'(IMEM_BYTES));
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch request/response channel between the core fetch stage and the controller.
// master = core side, slave = fetch controller.
interface imem_fetch_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, flush, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_err
  );

endinterface

// File: rtl/imem_wait_timer.sv
// Loadable down-counter with a zero flag for flash access timing.
// Latency: load/decrement take effect at the next edge; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module imem_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Sequences one 32-bit fetch from two lock-stepped x16 parallel flash ROMs.
// Latency: WAIT_CYCLES+2 cycles from accept to resp_valid (1 cycle for address faults).
// Backpressure: holds the response in RESP until resp_ready; flush drops any in-flight fetch.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int WAIT_CYCLES = 7,               // legal range 1..255
  parameter int ROM_ADDR_W  = ROM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_fetch_ctrl_if.slave      fetch,
  output logic                  flash_ce,
  output logic                  flash_oe,
  output logic                  flash_we,
  output logic                  flash_reset,
  output logic                  flash_byte,
  output logic [ROM_ADDR_W-1:0] flash_a,
  input  logic [15:0]           dq_lo,
  input  logic [15:0]           dq_hi
);

  imem_state_e state;
  logic        ce_q;
  logic        oe_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_instr_q;
  logic        timer_zero;
  logic        req_ready_w;
  logic        req_fire;

  // Reads only: the ROMs can never be written or switched out of x16 mode.
  assign flash_we    = 1'b1;
  assign flash_byte  = 1'b1;
  assign flash_reset = ~rst;

  assign req_ready_w = (state == IDLE) && !fetch.flush && !rst;
  assign req_fire    = fetch.req_valid && req_ready_w;

  imem_wait_timer #(.W(8)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == SETUP),
    .load_val (8'(WAIT_CYCLES - 1)),
    .dec      (state == READ),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ce_q         <= 1'b1;
      oe_q         <= 1'b1;
      flash_a      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_instr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (imem_addr_fault(fetch.req_addr)) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_instr_q <= '0;
              state        <= RESP;
            end else begin
              // flash_a only moves here, while CE is still high.
              flash_a <= ROM_ADDR_W'({fetch.req_addr[19:2], 1'b0});
              ce_q    <= 1'b0;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (fetch.flush) begin
            ce_q  <= 1'b1;
            state <= IDLE;
          end else begin
            oe_q  <= 1'b0;
            state <= READ;
          end
        end
        READ: begin
          if (fetch.flush) begin
            ce_q  <= 1'b1;
            oe_q  <= 1'b1;
            state <= IDLE;
          end else if (timer_zero) begin
            resp_instr_q <= {dq_hi, dq_lo};
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            ce_q         <= 1'b1;
            oe_q         <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (fetch.flush || fetch.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flash_ce         = ce_q;
  assign flash_oe         = oe_q;
  assign fetch.req_ready  = req_ready_w;
  assign fetch.resp_valid = resp_valid_q;
  assign fetch.resp_err   = resp_err_q;
  assign fetch.resp_instr = resp_instr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with WAIT_CYCLES=3 and behavioural x16 ROMs.
module tb_imem_fetch_ctrl;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_ce, flash_oe, flash_we, flash_reset, flash_byte;
  logic [18:0] flash_a;
  logic [15:0] dq_lo, dq_hi;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int oe_cnt = 0;

  logic [15:0] rom_lo [16];
  logic [15:0] rom_hi [16];
  logic        dq_ok;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(.WAIT_CYCLES(W), .ROM_ADDR_W(19)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch       (bus),
    .flash_ce    (flash_ce),
    .flash_oe    (flash_oe),
    .flash_we    (flash_we),
    .flash_reset (flash_reset),
    .flash_byte  (flash_byte),
    .flash_a     (flash_a),
    .dq_lo       (dq_lo),
    .dq_hi       (dq_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM data only becomes valid in the third cycle of OE low.
  always @(posedge clk) oe_cnt <= (!flash_ce && !flash_oe) ? oe_cnt + 1 : 0;
  assign dq_ok = !flash_ce && !flash_oe && (oe_cnt >= W - 1);
  assign dq_lo = dq_ok ? rom_lo[flash_a[4:1]] : 16'hDEAD;
  assign dq_hi = dq_ok ? rom_hi[flash_a[4:1]] : 16'hBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ce"},      32'(flash_ce), 32'd1);
    check({tag, " oe"},      32'(flash_oe), 32'd1);
    check({tag, " we"},      32'(flash_we), 32'd1);
    check({tag, " freset"},  32'(flash_reset), 32'd0);
    check({tag, " byte"},    32'(flash_byte), 32'd1);
    check({tag, " a"},       32'(flash_a), 32'd0);
    check({tag, " rdy"},     32'(bus.req_ready), 32'd0);
    check({tag, " rvld"},    32'(bus.resp_valid), 32'd0);
    check({tag, " rerr"},    32'(bus.resp_err), 32'd0);
    check({tag, " rinstr"},  bus.resp_instr, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response is taken.
  task automatic fetch(input string tag, input logic [31:0] addr, input int exp_lat,
                       input logic [31:0] exp_instr, input logic exp_err,
                       input int exp_ce_low, input logic [18:0] exp_a, output int resp_cyc);
    int  lat    = 0;
    int  ce_low = 0;
    int  a_bad  = 0;
    check({tag, " ce_idle"}, 32'(flash_ce), 32'd1);
    check({tag, " rdy"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    resp_cyc = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (!flash_ce) begin
        ce_low++;
        if (flash_a !== exp_a) a_bad++;
      end
      if (bus.resp_valid) begin
        lat = n;
        resp_cyc = cyc;
      end
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " instr"}, bus.resp_instr, exp_instr);
    check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
    check({tag, " ce_low"}, 32'(ce_low), 32'(exp_ce_low));
    check({tag, " a_stable"}, 32'(a_bad), 32'd0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " rvld_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  int c0, c1, c2, cnt;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_lo[i] = 16'h0;
      rom_hi[i] = 16'h0;
    end
    rom_hi[0] = 16'h0010; rom_lo[0] = 16'h0093;
    rom_hi[1] = 16'h0020; rom_lo[1] = 16'h8113;
    rom_hi[2] = 16'h0000; rom_lo[2] = 16'h0413;
    rom_hi[4] = 16'h1234; rom_lo[4] = 16'h52B7;

    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst freset", 32'(flash_reset), 32'd1);

    // Single fetch: word 2, CE low for SETUP + 3 READ cycles.
    fetch("single", 32'h8, 5, 32'h0000_0413, 1'b0, 4, 19'h4, c0);

    // Back-to-back fetches, one instruction per W+3 cycles.
    fetch("b2b0", 32'h0, 5, 32'h0010_0093, 1'b0, 4, 19'h0, c0);
    fetch("b2b1", 32'h4, 5, 32'h0020_8113, 1'b0, 4, 19'h2, c1);
    fetch("b2b2", 32'h8, 5, 32'h0000_0413, 1'b0, 4, 19'h4, c2);
    check("b2b gap01", 32'(c1 - c0), 32'd6);
    check("b2b gap12", 32'(c2 - c1), 32'd6);

    // Address faults answer in cycle 1 without touching the ROMs.
    fetch("misalign", 32'h6, 1, 32'h0, 1'b1, 0, 19'h0, c0);
    fetch("oor", 32'h0010_0000, 1, 32'h0, 1'b1, 0, 19'h0, c0);

    // Flush in the second READ cycle, held into IDLE to block acceptance.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush in_read oe", 32'(flash_oe), 32'd0);
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    @(negedge clk);
    check("flush ce", 32'(flash_ce), 32'd1);
    check("flush oe", 32'(flash_oe), 32'd1);
    check("flush rvld", 32'(bus.resp_valid), 32'd0);
    check("flush rdy", 32'(bus.req_ready), 32'd0);
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid || !flash_ce) cnt++;
    end
    check("flush quiet", 32'(cnt), 32'd0);
    fetch("after_flush", 32'h10, 5, 32'h1234_52B7, 1'b0, 4, 19'h8, c0);

    // Flush drops a pending response.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("flush_resp rvld", 32'(bus.resp_valid), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_resp drop", 32'(bus.resp_valid), 32'd0);

    // Backpressure: response held stable for 10 cycles.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    cnt = 0;
    for (int n = 0; n < 20 && !bus.resp_valid; n++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    held = bus.resp_instr;
    check("bp first", held, 32'h0000_0413);
    repeat (10) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_instr !== 32'h0000_0413) cnt++;
    end
    check("bp held", 32'(cnt), 32'd0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("bp taken", 32'(bus.resp_valid), 32'd0);

    // Reset during READ aborts the fetch with no response.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid) cnt++;
    end
    check("mid_rst no_resp", 32'(cnt), 32'd0);
    fetch("recover", 32'h4, 5, 32'h0020_8113, 1'b0, 4, 19'h2, c0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Read sequencer that fetches 32-bit RISC-V instructions from the two 16-bit S29AL008J-style parallel flash ROMs (lower half, upper half).
- Sits between the core's instruction-fetch stage and the flash pins.
- Accepts one fetch address per valid/ready handshake, drives chip-enable, output-enable and address to both ROMs in lock-step, and waits a programmable access time.
- Captures both DQ buses and returns the concatenated instruction through a valid/ready response channel.

Parameters:
- WAIT_CYCLES, 7, clk cycles OE is held low before DQ is sampled (tACC 70 ns at 100 MHz); legal range 1..255.
- ROM_ADDR_W, 19, width of flash address bus A.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  controller can accept request
- req_addr  in  32  byte address of instruction
- flush  in  1  abort in-flight fetch (branch/redirect)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_instr  out  32  {dq_hi, dq_lo} captured instruction
- resp_err  out  1  address fault (misaligned or out of range)
- flash_ce  out  1  chip enable to both ROMs, active low
- flash_oe  out  1  output enable to both ROMs, active low
- flash_we  out  1  write enable, active low; constant 1
- flash_reset  out  1  ROM reset, active low; 0 while rst, else 1
- flash_byte  out  1  word mode select; constant 1 (x16)
- flash_a  out  ROM_ADDR_W  address to both ROMs
- dq_lo  in  16  DQ of lower-half ROM
- dq_hi  in  16  DQ of upper-half ROM

Behaviour:
- Reset values:
  - Outputs: flash_ce=1, flash_oe=1, flash_we=1, flash_reset=0, flash_byte=1, flash_a=0, req_ready=0, resp_valid=0, resp_err=0, resp_instr=0.
  - Internal: state=IDLE, counter=0.
  - A reset asserted mid-fetch aborts immediately with no response.
- Address map: flash_a = {req_addr[19:2], 1'b0}. The ROM indexes on A[18:1], so instruction word n is stored at ROM word n.
- Address checks at acceptance:
  - Misaligned: req_addr[1:0] != 0.
  - Out of range: req_addr[31:20] != 0.
  - Either condition produces an error response.
- States: IDLE, SETUP, READ, RESP.
- IDLE:
  - req_ready = ~flush; ROMs deselected.
  - On req_valid && req_ready:
    - Fault address: go to RESP with resp_err=1, resp_instr=0. The ROMs are never selected.
    - Good address: latch flash_a, go to SETUP.
- SETUP (1 cycle):
  - flash_ce=0, flash_oe=1, flash_a stable.
  - Load counter with WAIT_CYCLES-1, go to READ.
- READ:
  - flash_ce=0, flash_oe=0, flash_a stable; counter decrements each cycle.
  - At counter==0, register {dq_hi, dq_lo} into resp_instr at this clock edge, then go to RESP.
  - READ therefore lasts exactly WAIT_CYCLES cycles.
- RESP:
  - flash_ce=1, flash_oe=1 (bus released, satisfies tDF); resp_valid=1; resp_instr and resp_err held stable.
  - On resp_ready, go to IDLE.
  - RESP is held indefinitely under backpressure.
- Latency: request accepted at edge 0 -> resp_valid high in cycle WAIT_CYCLES+2 (good address) or cycle 1 (fault).
  - Back-to-back throughput is one instruction per WAIT_CYCLES+3 cycles with resp_ready tied high.
  - The IDLE cycle guarantees at least one CE-high cycle between accesses.
- flush:
  - In SETUP or READ: abort to IDLE next cycle, CE/OE deasserted, no response issued.
  - In RESP: drop response, go to IDLE; flush wins over a simultaneous resp_ready.
  - In IDLE: req_ready forced 0, so no request is accepted that cycle.
- Stability rule: flash_a never changes while flash_ce=0. flash_a retains the last value in IDLE.
- The controller never drives DQ; flash_we is constant 1, so a ROM write is impossible.

Decomposition:
- Shared package imem_pkg holds:
  - State enum (IDLE, SETUP, READ, RESP).
  - ROM_ADDR_W default.
  - Address-check constants: IMEM_BYTES = 2^20 and the alignment mask.
- One natural sub-module, imem_wait_timer: loadable down-counter with a zero flag, reused later for write/erase sequencing.

Test Plan (WAIT_CYCLES=3, behavioural ROM models responding after 3 cycles of OE low):
- Single fetch, req_addr=0x00000008, ROMs hold hi=0x0000 lo=0x0413 at word 2 -> flash_a=0x00004; resp_valid in cycle 5; resp_instr=0x00000413; resp_err=0; CE low exactly 4 cycles.
- Back-to-back fetches at 0x0, 0x4, 0x8 with resp_ready=1 -> three responses spaced 6 cycles apart; CE high for at least 1 cycle between accesses; flash_a stable while CE=0.
- Misaligned req_addr=0x00000006 -> resp_valid in cycle 1, resp_err=1, resp_instr=0; flash_ce stays 1 throughout.
- Out-of-range req_addr=0x00100000 -> resp_err=1 in cycle 1; no ROM access.
- flush asserted in 2nd READ cycle -> IDLE next cycle, CE=OE=1, no resp_valid; a new request to 0x10 then completes normally with the correct data.
- Backpressure: resp_ready=0 for 10 cycles, plus rst asserted during READ on a second fetch -> resp_instr held stable until accepted; after rst all outputs at reset values, flash_reset=0, no response.
